// File: rtl/pixel_addr_gen.sv
// pixel_addr_gen -- raster-order pixel address walker.
//
// Walks a rectangular pixel region (x0, y0, w, h) row by row. For each pixel
// it emits one beat (out_x, out_y, out_addr) on a valid/ready stream, where
// out_addr = base_addr + out_y*stride + (out_x << bpp_log2), modulo 2^ADDR_W.
// The only multiply is the start-of-region address, registered in LOAD.
// Every later address comes from incremental adders.
//
// Ports:
//   clk, rst           clock, asynchronous active-high reset
//   start              job request, sampled only while idle
//   base_addr, stride  byte address of pixel (0,0), bytes per frame line
//   bpp_log2           log2 of bytes per pixel
//   x0, y0, w, h       region origin and size in pixels
//   busy, done         job in progress / one-cycle completion pulse
//   out_valid/ready    beat handshake
//   out_x, out_y       pixel coordinates of the current beat
//   out_addr, out_last byte address of the current beat, final-beat marker
//
// Optional feature (macro PIXEL_ADDR_GEN_LIMIT_EN): adds input limit_addr,
// latched at start, and output out_oob. out_oob flags beats whose address is
// >= limit_addr. Such beats are still emitted.

module pixel_addr_gen #(
    parameter int COORD_W    = 10,
    parameter int ADDR_W     = 32,
    parameter int BPP_LOG2_W = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_W-1:0]     base_addr,
    input  logic [ADDR_W-1:0]     stride,
    input  logic [BPP_LOG2_W-1:0] bpp_log2,
    input  logic [COORD_W-1:0]    x0,
    input  logic [COORD_W-1:0]    y0,
    input  logic [COORD_W-1:0]    w,
    input  logic [COORD_W-1:0]    h,
    output logic                  busy,
    output logic                  done,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [COORD_W-1:0]    out_x,
    output logic [COORD_W-1:0]    out_y,
    output logic [ADDR_W-1:0]     out_addr,
    output logic                  out_last
`ifdef PIXEL_ADDR_GEN_LIMIT_EN
    ,
    input  logic [ADDR_W-1:0]     limit_addr,
    output logic                  out_oob
`endif
);

    typedef enum logic [1:0] {IDLE, LOAD, RUN, FIN} state_t;

    state_t                  state;
    logic [ADDR_W-1:0]       base_q;
    logic [ADDR_W-1:0]       stride_q;
    logic [BPP_LOG2_W-1:0]   bpp_q;
    logic [COORD_W-1:0]      x0_q;
    logic [COORD_W-1:0]      y0_q;
    logic [COORD_W-1:0]      x_end;     // x0 + w - 1
    logic [COORD_W-1:0]      y_end;     // y0 + h - 1
    logic [ADDR_W-1:0]       row_addr;  // address of pixel (x0, out_y)
`ifdef PIXEL_ADDR_GEN_LIMIT_EN
    logic [ADDR_W-1:0]       limit_q;
`endif

    logic [ADDR_W-1:0]       pix_bytes;
    logic [COORD_W-1:0]      nxt_x;
    logic [COORD_W-1:0]      nxt_y;
    logic [ADDR_W-1:0]       nxt_addr;
    logic [ADDR_W-1:0]       nxt_row;
    logic                    nxt_last;
    logic                    load_beat;

    assign pix_bytes = ADDR_W'(1) << bpp_q;

    // A new beat enters the output register when nothing is held yet, or
    // when a non-final beat is consumed.
    assign load_beat = (state == RUN) && (!out_valid || (out_ready && !out_last));

    // Next-beat computation. An empty output register takes the first beat
    // straight from row_addr. The end of a row rolls to the next row.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves one unassigned (no latch).
        nxt_x    = out_x;
        nxt_y    = out_y;
        nxt_addr = out_addr;
        nxt_row  = row_addr;
        if (!out_valid) begin
            nxt_x    = x0_q;
            nxt_y    = y0_q;
            nxt_addr = row_addr;
        end else if (out_x == x_end) begin
            nxt_x    = x0_q;
            nxt_y    = out_y + COORD_W'(1);
            nxt_row  = row_addr + stride_q;
            nxt_addr = row_addr + stride_q;
        end else begin
            nxt_x    = out_x + COORD_W'(1);
            nxt_addr = out_addr + pix_bytes;
        end
        nxt_last = (nxt_x == x_end) && (nxt_y == y_end);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
            state     <= IDLE;
            base_q    <= '0;
            stride_q  <= '0;
            bpp_q     <= '0;
            x0_q      <= '0;
            y0_q      <= '0;
            x_end     <= '0;
            y_end     <= '0;
            row_addr  <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            out_valid <= 1'b0;
            out_x     <= '0;
            out_y     <= '0;
            out_addr  <= '0;
            out_last  <= 1'b0;
`ifdef PIXEL_ADDR_GEN_LIMIT_EN
            limit_q   <= '0;
            out_oob   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        base_q   <= base_addr;
                        stride_q <= stride;
                        bpp_q    <= bpp_log2;
                        x0_q     <= x0;
                        y0_q     <= y0;
                        x_end    <= x0 + w - COORD_W'(1);
                        y_end    <= y0 + h - COORD_W'(1);
`ifdef PIXEL_ADDR_GEN_LIMIT_EN
                        limit_q  <= limit_addr;
`endif
                        busy     <= 1'b1;
                        state    <= (w == '0 || h == '0) ? FIN : LOAD;
                    end
                end
                LOAD: begin
                    row_addr <= base_q + ADDR_W'(y0_q) * stride_q
                                + (ADDR_W'(x0_q) << bpp_q);
                    state    <= RUN;
                end
                RUN: begin
                    if (load_beat) begin
                        out_valid <= 1'b1;
                        out_x     <= nxt_x;
                        out_y     <= nxt_y;
                        out_addr  <= nxt_addr;
                        out_last  <= nxt_last;
                        row_addr  <= nxt_row;
`ifdef PIXEL_ADDR_GEN_LIMIT_EN
                        out_oob   <= (nxt_addr >= limit_q);
`endif
                    end else if (out_valid && out_ready && out_last) begin
                        out_valid <= 1'b0;
                        out_last  <= 1'b0;
`ifdef PIXEL_ADDR_GEN_LIMIT_EN
                        out_oob   <= 1'b0;
`endif
                        state     <= FIN;
                    end
                end
                FIN: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pixel_addr_gen.sv
// tb_pixel_addr_gen -- scoreboard bench for pixel_addr_gen.
//
// A reference model expands each job into its expected beats with plain
// loops and pushes them into a queue. A monitor compares every presented beat
// with the queue head and pops it on a transfer. A stalled beat is compared
// again on each stalled cycle, so it must stay stable. Covers directed jobs
// (basic raster, backpressure, pixel size/wrap, zero size, reset mid-job) and
// randomized jobs with random ready, stray starts and input churn.
// With PIXEL_ADDR_GEN_LIMIT_EN defined, out_oob is part of each beat compare.

module tb_pixel_addr_gen;

    logic        tb_clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] base_addr, stride;
    logic [2:0]  bpp_log2;
    logic [9:0]  x0, y0, w, h;
    logic        busy, done, out_valid, out_ready, out_last;
    logic [9:0]  out_x, out_y;
    logic [31:0] out_addr;
    logic        oob_act;
`ifdef PIXEL_ADDR_GEN_LIMIT_EN
    logic [31:0] limit_addr;
    logic        out_oob;
    assign oob_act = out_oob;
`else
    assign oob_act = 1'b0;
`endif

    pixel_addr_gen #(.COORD_W(10), .ADDR_W(32), .BPP_LOG2_W(3)) dut (
        .clk(tb_clk), .rst(rst), .start(start),
        .base_addr(base_addr), .stride(stride), .bpp_log2(bpp_log2),
        .x0(x0), .y0(y0), .w(w), .h(h),
        .busy(busy), .done(done),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_x(out_x), .out_y(out_y), .out_addr(out_addr), .out_last(out_last)
`ifdef PIXEL_ADDR_GEN_LIMIT_EN
        , .limit_addr(limit_addr), .out_oob(out_oob)
`endif
    );

    always #5 tb_clk = ~tb_clk;

    typedef struct packed {
        logic [9:0]  x;
        logic [9:0]  y;
        logic [31:0] addr;
        logic        last;
        logic        oob;
    } beat_t;

    beat_t exp_q[$];
    int    n_cmp = 0;
    int    n_bad = 0;
    int    cyc = 0;
    int    n_pop = 0;
    int    last_cyc = -1;
    int    first_valid_cyc = -1;
    int    done_cnt = 0;
    int    ready_mode = 0;
    int    ready_idx = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge tb_clk) cyc <= cyc + 1;

    // Ready driver: 0 = always ready, 1 = pattern 1,0,0,1,0,1, 2 = random.
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge tb_clk);
            #1;
            case (ready_mode)
                1: begin
                    out_ready = (ready_idx % 6 == 0) || (ready_idx % 6 == 3) || (ready_idx % 6 == 5);
                    ready_idx++;
                end
                2:       out_ready = ($urandom_range(0, 3) != 0);
                default: out_ready = 1'b1;
            endcase
        end
    end

    // Monitor / scoreboard: compares presented beats with the queue head.
    always @(negedge tb_clk) begin
        if (!rst) begin
            if (done) done_cnt++;
            if (out_valid) begin
                if (first_valid_cyc < 0) first_valid_cyc = cyc;
                if (exp_q.size() == 0) begin
                    check("unexpected_beat", {22'd0, out_x, out_y, out_addr}, 64'd0);
                end else begin
                    check("beat", {10'd0, out_x, out_y, out_addr, out_last, oob_act}, {10'd0, exp_q[0]});
                    if (out_ready) begin
                        if (exp_q[0].last) last_cyc = cyc;
                        void'(exp_q.pop_front());
                        n_pop++;
                    end
                end
            end
        end
    end

    // Reference model: the region expanded row by row with plain arithmetic.
    task automatic push_model(input logic [31:0] b, s, input logic [2:0] bpp,
                              input logic [9:0] px, py, pw, ph, input logic [31:0] lim);
        beat_t bt;
        for (int yy = 0; yy < int'(ph); yy++) begin
            for (int xx = 0; xx < int'(pw); xx++) begin
                bt.x    = 10'(int'(px) + xx);
                bt.y    = 10'(int'(py) + yy);
                bt.addr = b + 32'(bt.y) * s + (32'(bt.x) << bpp);
                bt.last = (yy == int'(ph) - 1) && (xx == int'(pw) - 1);
`ifdef PIXEL_ADDR_GEN_LIMIT_EN
                bt.oob  = (bt.addr >= lim);
`else
                bt.oob  = 1'b0;
`endif
                exp_q.push_back(bt);
            end
        end
    endtask

    task automatic scramble_inputs();
        base_addr = $urandom;
        stride    = $urandom;
        bpp_log2  = 3'($urandom);
        x0        = 10'($urandom);
        y0        = 10'($urandom);
        w         = 10'($urandom);
        h         = 10'($urandom);
`ifdef PIXEL_ADDR_GEN_LIMIT_EN
        limit_addr = $urandom;
`endif
    endtask

    // Drives start for one cycle. Returns the cycle number at which start was applied.
    task automatic start_job(input logic [31:0] b, s, input logic [2:0] bpp,
                             input logic [9:0] px, py, pw, ph, input logic [31:0] lim,
                             output int s0);
        push_model(b, s, bpp, px, py, pw, ph, lim);
        first_valid_cyc = -1;
        last_cyc = -1;
        @(posedge tb_clk);
        #1;
        base_addr = b; stride = s; bpp_log2 = bpp;
        x0 = px; y0 = py; w = pw; h = ph;
`ifdef PIXEL_ADDR_GEN_LIMIT_EN
        limit_addr = lim;
`else
        if (lim != 32'd0) s0 = 0;  // limit unused without the feature
`endif
        start = 1'b1;
        s0 = cyc;
    endtask

    task automatic run_job(input logic [31:0] b, s, input logic [2:0] bpp,
                           input logic [9:0] px, py, pw, ph, input logic [31:0] lim,
                           input bit stray);
        int s0, done_cyc, busy_cnt, budget;
        bit got_done;
        start_job(b, s, bpp, px, py, pw, ph, lim, s0);
        budget = int'(pw) * int'(ph) * 12 + 40;
        got_done = 0; busy_cnt = 0; done_cyc = -1;
        for (int i = 0; i < budget && !got_done; i++) begin
            @(posedge tb_clk);
            #1;
            scramble_inputs();
            start = stray && busy && ($urandom_range(0, 3) == 0);
            @(negedge tb_clk);
            if (busy) busy_cnt++;
            if (done) begin
                got_done = 1;
                done_cyc = cyc;
            end
        end
        check("done_seen", 64'(got_done), 64'd1);
        if (got_done) begin
            if (pw != 0 && ph != 0) begin
                check("first_valid_latency", 64'(first_valid_cyc - s0), 64'd3);
                check("done_after_last", 64'(done_cyc - last_cyc), 64'd2);
                check("queue_drained", 64'(exp_q.size()), 64'd0);
            end else begin
                check("zero_done_latency", 64'(done_cyc - s0), 64'd2);
                check("zero_busy_cycles", 64'(busy_cnt), 64'd1);
                check("zero_no_valid", 64'(first_valid_cyc), 64'hFFFF_FFFF_FFFF_FFFF);
            end
            @(negedge tb_clk);
            check("done_one_cycle", 64'({done, busy}), 64'd0);
        end
        exp_q.delete();
        start = 1'b0;
    endtask

    initial begin
        int s0, dc;
        bit hit;
        rst = 1'b1;
        start = 1'b0;
        scramble_inputs();
        #3;
        check("reset_state", {13'd0, busy, done, out_valid, out_last, oob_act, out_x, out_y, out_addr}, 64'd0);
        repeat (2) @(negedge tb_clk);
        rst = 1'b0;

        // Basic raster, then the same job under the 1,0,0,1,0,1 backpressure pattern.
        ready_mode = 0;
        run_job(32'h0800_0000, 32'h280, 3'd0, 10'd2, 10'd1, 10'd3, 10'd2, 32'h0800_0500, 1'b0);
        ready_mode = 1; ready_idx = 0;
        run_job(32'h0800_0000, 32'h280, 3'd0, 10'd2, 10'd1, 10'd3, 10'd2, 32'h0800_0500, 1'b0);

        // Pixel size and address wrap.
        ready_mode = 0;
        run_job(32'hFFFF_FFF8, 32'h10, 3'd2, 10'd0, 10'd0, 10'd4, 10'd1, 32'h0000_0004, 1'b0);

        // Zero-size region.
        run_job(32'h1234_0000, 32'h40, 3'd1, 10'd7, 10'd3, 10'd0, 10'd5, 32'h0, 1'b0);

        // Reset mid-job after the 2nd beat transfers.
        n_pop = 0;
        start_job(32'h0800_0000, 32'h280, 3'd0, 10'd2, 10'd1, 10'd3, 10'd2, 32'h0800_0500, s0);
        @(posedge tb_clk);
        #1 start = 1'b0;
        hit = 0;
        for (int i = 0; i < 50 && !hit; i++) begin
            @(negedge tb_clk);
            hit = (n_pop >= 2);
        end
        check("reset_job_progress", 64'(hit), 64'd1);
        @(posedge tb_clk);
        #3 rst = 1'b1;
        #1;
        check("mid_reset_outputs", {13'd0, busy, done, out_valid, out_last, oob_act, out_x, out_y, out_addr}, 64'd0);
        exp_q.delete();
        repeat (2) @(negedge tb_clk);
        rst = 1'b0;
        dc = done_cnt;
        repeat (6) @(negedge tb_clk);
        check("no_done_after_abort", 64'(done_cnt - dc), 64'd0);
        run_job(32'h0800_0000, 32'h280, 3'd0, 10'd2, 10'd1, 10'd3, 10'd2, 32'h0800_0500, 1'b0);

        // Randomized jobs: random ready, stray starts, churning inputs.
        for (int j = 0; j < 30; j++) begin
            logic [31:0] rb, rs, rl;
            logic [9:0]  rx, ry, rw, rh;
            logic [2:0]  rp;
            rb = $urandom; rs = $urandom; rl = $urandom;
            rp = 3'($urandom_range(0, 7));
            rx = 10'($urandom_range(0, 1000));
            ry = 10'($urandom_range(0, 1000));
            rw = 10'(($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 6));
            rh = 10'($urandom_range(1, 5));
            ready_mode = $urandom_range(0, 2);
            run_job(rb, rs, rp, rx, ry, rw, rh, rl, 1'b1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/pixel_addr_gen.md
Name: pixel_addr_gen

Overview:
- Sequential, parametrised successor to the combinational address calculator.
- Given a rectangular pixel region, base address, line stride and pixel size, it walks the region in raster order.
- Emits one (x, y, address) beat per cycle on a valid/ready stream.
- Sits between the Julia worker's job dispatcher and the pixel writer / memory request stage.

Parameters:
COORD_W, 10, width of x/y coordinates and region width/height
ADDR_W, 32, width of byte addresses and stride
BPP_LOG2_W, 3, width of the bytes-per-pixel exponent (bytes per pixel = 1 << bpp_log2)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous active-high reset
start  input  1  single-cycle job request; sampled only in IDLE
base_addr  input  ADDR_W  byte address of pixel (0,0)
stride  input  ADDR_W  bytes per frame line
bpp_log2  input  BPP_LOG2_W  log2 of bytes per pixel
x0  input  COORD_W  region origin x
y0  input  COORD_W  region origin y
w  input  COORD_W  region width in pixels
h  input  COORD_W  region height in pixels
busy  output  1  high from the cycle after start is accepted until done
done  output  1  one-cycle pulse when the job completes
out_valid  output  1  beat valid
out_ready  input  1  downstream accepts beat
out_x  output  COORD_W  pixel x
out_y  output  COORD_W  pixel y
out_addr  output  ADDR_W  base_addr + out_y*stride + (out_x << bpp_log2), modulo 2^ADDR_W
out_last  output  1  marks the final beat of the job

Behaviour:
- Reset (asynchronous, active-high):
  - State returns to IDLE.
  - busy, done, out_valid and out_last go to 0.
  - out_x, out_y and out_addr go to 0.
- States: IDLE, LOAD, RUN, FIN.
- IDLE:
  - On start=1, latch all job inputs and go to LOAD.
  - If w==0 or h==0, go directly to FIN instead.
- LOAD (1 cycle):
  - row_addr <= base + y0*stride + (x0<<bpp_log2). This is the only multiply; it is registered.
  - Next state RUN.
  - out_valid rises on the 2nd rising edge after the start sample.
- RUN: the output register holds the current beat.
  - Advance on the transfer condition out_valid && out_ready.
  - Between transfers all out_* are held stable (no change while out_valid && !out_ready).
  - Column advance: out_x+1, out_addr += (1<<bpp_log2).
  - End of row: out_x <= x0, out_y+1, row_addr += stride, out_addr <= new row_addr.
  - Incremental adders only; no multiplier in RUN.
  - out_last=1 exactly on the beat where (out_x == x0+w-1) && (out_y == y0+h-1).
  - Transfer of the last beat: out_valid -> 0 the next cycle; go to FIN.
- FIN (1 cycle): done=1, busy=0 on the following cycle; return to IDLE.
- Throughput: 1 beat per cycle with out_ready held high; w*h beats total.
- Arithmetic:
  - Addresses wrap modulo 2^ADDR_W.
  - Coordinates wrap modulo 2^COORD_W; callers must not rely on coordinate wrap.
- start while busy: ignored, no effect.
- Reset mid-job: immediate abort; no done pulse; next start begins a fresh job.
- Job inputs may change after the start cycle without affecting the running job.

Optional Feature:
- Macro PIXEL_ADDR_GEN_LIMIT_EN.
- Defined:
  - Adds input limit_addr [ADDR_W] (latched at start) and output out_oob [1].
  - out_oob=1 alongside out_valid when out_addr >= limit_addr.
  - Beats are still emitted; out_oob is reset to 0.
- Undefined: neither port exists and no compare logic is built.

Test Plan:
- Basic raster: base=0x08000000, stride=0x280, bpp_log2=0, x0=2, y0=1, w=3, h=2, out_ready=1.
  - Addrs 0x08000282, 0x08000283, 0x08000284, 0x08000502, 0x08000503, 0x08000504.
  - out_last on the 6th beat only; done 1 cycle after the last transfer.
- Backpressure: same job; out_ready toggles 1,0,0,1,0,1...
  - No beat lost or duplicated; outputs stable while stalled.
  - Same 6 addresses in order.
- Pixel size and wrap: base=0xFFFFFFF8, stride=0x10, bpp_log2=2, region (0,0) w=4 h=1.
  - Addrs 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000, 0x00000004.
- Zero-size: w=0, h=5, start.
  - No out_valid ever; done pulses 2 cycles after start; busy high for 1 cycle.
- Reset mid-job: assert rst after the 2nd beat of the basic job.
  - All outputs 0 immediately (asynchronous); no done.
  - Restarted job yields the full 6-beat sequence.
- With PIXEL_ADDR_GEN_LIMIT_EN, limit_addr=0x08000500 on the basic job: out_oob=0 for beats 1-3, 1 for beats 4-6.
